mem_port_arbiter: RTL

//  Shares the single-port 256x16 synchronous RAM of the multicycle computer between two requesters.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/read-return bundle between two RAM requesters, the arbiter and the RAM.
// The arbiter uses the slave modport; the requesters and RAM model use master.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          A_Req;
    logic          A_WE;
    logic [AW-1:0] A_Addr;
    logic [DW-1:0] A_WData;
    logic          A_Gnt;
    logic          A_RValid;
    logic [DW-1:0] A_RData;

    logic          B_Req;
    logic          B_WE;
    logic [AW-1:0] B_Addr;
    logic [DW-1:0] B_WData;
    logic          B_Gnt;
    logic          B_RValid;
    logic [DW-1:0] B_RData;

    logic [AW-1:0] MEM_Addr;
    logic [DW-1:0] MEM_WData;
    logic          MEM_WE;
    logic [DW-1:0] MEM_RData;

    logic [2:0]    B_WaitCnt;

    modport slave (
        input  A_Req, A_WE, A_Addr, A_WData,
        input  B_Req, B_WE, B_Addr, B_WData,
        input  MEM_RData,
        output A_Gnt, A_RValid, A_RData,
        output B_Gnt, B_RValid, B_RData,
        output MEM_Addr, MEM_WData, MEM_WE,
        output B_WaitCnt
    );

    modport master (
        output A_Req, A_WE, A_Addr, A_WData,
        output B_Req, B_WE, B_Addr, B_WData,
        output MEM_RData,
        input  A_Gnt, A_RValid, A_RData,
        input  B_Gnt, B_RValid, B_RData,
        input  MEM_Addr, MEM_WData, MEM_WE,
        input  B_WaitCnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: fixed priority to the loader
// port A, with a starvation guard that lets the CPU port B through after MAX_WAIT denials.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input logic             clk,
    input logic             Rst,
    mem_port_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | no read issued last cycle
    // RD_A  | read granted to A last cycle, RAM data belongs to A now
    // RD_B  | read granted to B last cycle, RAM data belongs to B now
    typedef enum logic [1:0] {IDLE, RD_A, RD_B} state_t;

    localparam logic [2:0] WAIT_LIM = 3'(MAX_WAIT);

    state_t     state;
    logic [2:0] wait_cnt;
    logic       gnt_a;
    logic       gnt_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!Rst) begin
            if (bus.A_Req && bus.B_Req) begin
                if (wait_cnt == WAIT_LIM) gnt_b = 1'b1;
                else                      gnt_a = 1'b1;
            end else begin
                gnt_a = bus.A_Req;
                gnt_b = bus.B_Req;
            end
        end
    end

    always_comb begin
        bus.MEM_Addr  = '0;
        bus.MEM_WData = '0;
        bus.MEM_WE    = 1'b0;
        if (gnt_a) begin
            bus.MEM_Addr  = bus.A_Addr;
            bus.MEM_WData = bus.A_WData;
            bus.MEM_WE    = bus.A_WE;
        end else if (gnt_b) begin
            bus.MEM_Addr  = bus.B_Addr;
            bus.MEM_WData = bus.B_WData;
            bus.MEM_WE    = bus.B_WE;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            if (gnt_a && !bus.A_WE)      state <= RD_A;
            else if (gnt_b && !bus.B_WE) state <= RD_B;
            else                         state <= IDLE;

            if (bus.B_Req && !gnt_b) begin
                if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Rst gates the strobes so a read in flight when reset arrives is never delivered.
    assign bus.A_Gnt     = gnt_a;
    assign bus.B_Gnt     = gnt_b;
    assign bus.A_RValid  = (state == RD_A) && !Rst;
    assign bus.B_RValid  = (state == RD_B) && !Rst;
    assign bus.A_RData   = bus.MEM_RData;
    assign bus.B_RData   = bus.MEM_RData;
    assign bus.B_WaitCnt = wait_cnt;
endmodule
